// File: rtl/rx_deframer_pkg.sv
// Shared definitions for the serial receive deframer.
//   state_t           : deframer FSM state encoding
//   DATA_BITS_DEFAULT : default number of data bits per frame
//   CNT_W             : width of the data-bit counter (covers 0..7)
//   even_parity_err() : 1 when data plus received parity bit has odd weight
package rx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  localparam int DATA_BITS_DEFAULT = 8;
  localparam int CNT_W             = 3;

  // Unused upper data bits are held at 0, so they do not disturb the XOR.
  function automatic logic even_parity_err(input logic [7:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction

endpackage

// File: rtl/rx_out_buffer.sv
// Single-entry holding register between the deframer and its consumer.
//   clk, reset     : falling-edge clock, asynchronous active-high reset
//   load           : a frame completed this cycle
//   load_data/perr : contents of the completed frame
//   ready          : consumer accepts the held frame when high with valid
//   data/perr/valid: held frame and its status
//   overrun        : one-cycle pulse when a completed frame is dropped
module rx_out_buffer
  import rx_deframer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_perr,
  input  logic       ready,
  output logic [7:0] data,
  output logic       perr,
  output logic       valid,
  output logic       overrun
);

  // Holding register: accept-and-reload in one cycle is allowed, otherwise a
  // new frame arriving on a full buffer is dropped and flagged.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      data    <= 8'h00;
      perr    <= 1'b0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        if (!valid || ready) begin
          data  <= load_data;
          perr  <= load_perr;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_deframer.sv
// Serial receive deframer: start bit, DATA_BITS data bits (LSB first),
// optional even parity bit, one stop bit. Advances only on bit_tick.
//   sc_clk_ctrl   : clock, all state changes on its falling edge
//   reset         : asynchronous active-high reset
//   S_data_in     : sampled serial line, valid when bit_tick is high
//   bit_tick      : one-cycle bit strobe
//   rx_ready      : consumer accept
//   rx_data       : received byte, unused MSBs 0
//   rx_valid      : rx_data holds an unaccepted frame
//   rx_parity_err : parity mismatch for the frame in rx_data
//   frame_err     : one-cycle pulse, stop bit sampled 0
//   overrun       : one-cycle pulse, completed frame dropped (buffer full)
module rx_deframer
  import rx_deframer_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int PARITY_EN = 0
) (
  input  logic       sc_clk_ctrl,
  input  logic       reset,
  input  logic       S_data_in,
  input  logic       bit_tick,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       shreg_r;
  logic             perr_r;
  logic             frame_err_r;
  logic             complete_s;
  logic             load_perr_s;

  // A frame completes on the stop-bit tick when the stop bit is 1.
  always_comb begin
    complete_s  = 1'b0;
    load_perr_s = 1'b0;
    if (bit_tick && (state_r == ST_STOP) && S_data_in) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
    if (PARITY_EN != 0) begin
      load_perr_s = perr_r;
    end else begin
      load_perr_s = 1'b0;
    end
  end

  // Frame FSM with bit counter, shift register and registered error pulse.
  always_ff @(negedge sc_clk_ctrl or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      shreg_r     <= 8'h00;
      perr_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if (bit_tick) begin
        case (state_r)
          ST_IDLE: begin
            if (!S_data_in) begin
              state_r <= ST_DATA;
              cnt_r   <= '0;
              shreg_r <= 8'h00;
              perr_r  <= 1'b0;
            end
          end
          ST_DATA: begin
            // Bit n lands at position n, giving LSB-first assembly directly.
            shreg_r[cnt_r] <= S_data_in;
            if (cnt_r == LAST_CNT) begin
              cnt_r   <= '0;
              state_r <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_PARITY: begin
            perr_r  <= even_parity_err(shreg_r, S_data_in);
            state_r <= ST_STOP;
          end
          ST_STOP: begin
            if (S_data_in) begin
              state_r <= ST_IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            // Line break: wait for the line to return high before hunting.
            if (S_data_in) begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign frame_err = frame_err_r;

  rx_out_buffer u_out_buffer (
    .clk       (sc_clk_ctrl),
    .reset     (reset),
    .load      (complete_s),
    .load_data (shreg_r),
    .load_perr (load_perr_s),
    .ready     (rx_ready),
    .data      (rx_data),
    .perr      (rx_parity_err),
    .valid     (rx_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_rx_deframer.sv
// Self-checking bench for rx_deframer: an 8N1 instance (dut0) and an 8E1
// instance (dut1), directed vector tables, hand-written corner sequences and
// a randomized run checked against a frame-level reference model.
module tb_rx_deframer;

  logic       clk;
  logic       reset;
  logic       tick0, d0, rdy0, tick1, d1, rdy1;
  logic [7:0] data0, data1;
  logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

  int checks;
  int errors;

  rx_deframer #(.DATA_BITS(8), .PARITY_EN(0)) dut0 (
    .sc_clk_ctrl(clk), .reset(reset), .S_data_in(d0), .bit_tick(tick0),
    .rx_ready(rdy0), .rx_data(data0), .rx_valid(v0), .rx_parity_err(pe0),
    .frame_err(fe0), .overrun(ov0)
  );

  rx_deframer #(.DATA_BITS(8), .PARITY_EN(1)) dut1 (
    .sc_clk_ctrl(clk), .reset(reset), .S_data_in(d1), .bit_tick(tick1),
    .rx_ready(rdy1), .rx_data(data1), .rx_valid(v1), .rx_parity_err(pe1),
    .frame_err(fe1), .overrun(ov1)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Monitor: sampled mid-cycle, after the bench has driven the inputs that
  // the next falling edge will see.
  logic       mon_en;
  logic [8:0] got0[$];
  logic [8:0] got1[$];
  int         fe_cnt0, fe_cnt1, ov_cnt0, ov_cnt1;

  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (v0 && rdy0) got0.push_back({pe0, data0});
      if (v1 && rdy1) got1.push_back({pe1, data1});
      if (fe0) fe_cnt0++;
      if (fe1) fe_cnt1++;
      if (ov0) ov_cnt0++;
      if (ov1) ov_cnt1++;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs of one DUT, let the falling edge happen,
  // return mid-cycle with outputs of that edge stable.
  task automatic cyc(input int w, input logic t, input logic d, input logic r);
    if (w == 0) begin
      tick0 = t; d0 = d; rdy0 = r; tick1 = 1'b0;
    end else begin
      tick1 = t; d1 = d; rdy1 = r; tick0 = 1'b0;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Gapless frame; rs is rx_ready during the stop-bit tick, rb elsewhere.
  task automatic send_frame(input int w, input logic [7:0] data, input logic pbit,
                            input logic stop, input logic rb, input logic rs);
    cyc(w, 1'b1, 1'b0, rb);
    for (int i = 0; i < 8; i++) cyc(w, 1'b1, data[i], rb);
    if (w == 1) cyc(w, 1'b1, pbit, rb);
    cyc(w, 1'b1, stop, rs);
  endtask

  // Random gap of 0..15 non-tick cycles with junk on the line, then a tick.
  task automatic rtick(input int w, input logic d);
    int g;
    g = $urandom_range(0, 15);
    for (int i = 0; i < g; i++) cyc(w, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    cyc(w, 1'b1, d, 1'b1);
  endtask

  // Randomized frames against a frame-level model: every good frame is
  // delivered once with its parity verdict; every bad stop gives one frame_err.
  task automatic random_run(input int w);
    logic [8:0] expq[$];
    logic [7:0] b;
    logic       p, perr_exp;
    int         fe_exp, k;
    fe_exp = 0;
    got0.delete();
    got1.delete();
    fe_cnt0 = 0; fe_cnt1 = 0; ov_cnt0 = 0; ov_cnt1 = 0;
    mon_en = 1'b1;
    for (int f = 0; f < 16; f++) begin
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) rtick(w, 1'b1);
      b = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      rtick(w, 1'b0);
      for (int i = 0; i < 8; i++) rtick(w, b[i]);
      if (w == 1) rtick(w, p);
      if ($urandom_range(0, 5) == 0) begin
        rtick(w, 1'b0);
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) rtick(w, 1'b0);
        rtick(w, 1'b1);
        fe_exp++;
      end else begin
        rtick(w, 1'b1);
        perr_exp = 1'b0;
        if (w == 1) begin
          perr_exp = 1'b0;
          for (int i = 0; i < 8; i++) perr_exp = perr_exp ^ b[i];
          perr_exp = perr_exp ^ p;
        end
        expq.push_back({perr_exp, b});
      end
    end
    for (int i = 0; i < 4; i++) cyc(w, 1'b0, 1'b1, 1'b1);
    mon_en = 1'b0;
    if (w == 0) begin
      chki("rand0_count", got0.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
        if (i < got0.size()) chk8("rand0_byte", got0[i][7:0], expq[i][7:0]);
      chki("rand0_frame_err", fe_cnt0, fe_exp);
      chki("rand0_overrun", ov_cnt0, 0);
    end else begin
      chki("rand1_count", got1.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
        if (i < got1.size()) begin
          chk8("rand1_byte", got1[i][7:0], expq[i][7:0]);
          chk1("rand1_perr", got1[i][8], expq[i][8]);
        end
      chki("rand1_frame_err", fe_cnt1, fe_exp);
      chki("rand1_overrun", ov_cnt1, 0);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec0_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       exp_perr;
  } vec1_t;

  vec0_t t0[5];
  vec1_t t1[6];

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    tick0 = 1'b0; d0 = 1'b1; rdy0 = 1'b1;
    tick1 = 1'b0; d1 = 1'b1; rdy1 = 1'b1;
    reset = 1'b1;

    t0[0] = '{8'h2A, 1'b1, 1'b1, 1'b0};
    t0[1] = '{8'hC3, 1'b1, 1'b1, 1'b0};
    t0[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    t0[3] = '{8'h5A, 1'b0, 1'b0, 1'b1};
    t0[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};

    t1[0] = '{8'h0F, 1'b1, 1'b1};
    t1[1] = '{8'h0F, 1'b0, 1'b0};
    t1[2] = '{8'h01, 1'b1, 1'b0};
    t1[3] = '{8'h01, 1'b0, 1'b1};
    t1[4] = '{8'hFF, 1'b0, 1'b0};
    t1[5] = '{8'h80, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk8("reset_data0", data0, 8'h00);
    chk1("reset_valid0", v0, 1'b0);
    chk1("reset_perr0", pe0, 1'b0);
    chk1("reset_ferr0", fe0, 1'b0);
    chk1("reset_ovr0", ov0, 1'b0);
    chk1("reset_valid1", v1, 1'b0);
    reset = 1'b0;
    cyc(0, 1'b0, 1'b1, 1'b1);

    // 8N1 table
    for (int i = 0; i < 5; i++) begin
      send_frame(0, t0[i].data, 1'b0, t0[i].stop, 1'b1, 1'b1);
      chk1("t0_valid", v0, t0[i].exp_valid);
      chk1("t0_ferr", fe0, t0[i].exp_ferr);
      chk1("t0_ovr", ov0, 1'b0);
      if (t0[i].exp_valid) chk8("t0_data", data0, t0[i].data);
      cyc(0, 1'b1, 1'b1, 1'b1);
      chk1("t0_valid_drop", v0, 1'b0);
      chk1("t0_ferr_drop", fe0, 1'b0);
    end

    // 8E1 parity table
    for (int i = 0; i < 6; i++) begin
      send_frame(1, t1[i].data, t1[i].pbit, 1'b1, 1'b1, 1'b1);
      chk1("t1_valid", v1, 1'b1);
      chk8("t1_data", data1, t1[i].data);
      chk1("t1_perr", pe1, t1[i].exp_perr);
      cyc(1, 1'b0, 1'b1, 1'b1);
      chk1("t1_valid_drop", v1, 1'b0);
    end

    // Break: stop bit 0, line held low 3 more ticks, then recovery
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    chk1("brk_ferr", fe0, 1'b1);
    chk1("brk_valid", v0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b1);
    chk1("brk_ferr_once", fe0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b1, 1'b0, 1'b1);
    chk1("brk_hold_valid", v0, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b1);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
    chk1("brk_rec_valid", v0, 1'b1);
    chk8("brk_rec_data", data0, 8'h55);
    cyc(0, 1'b0, 1'b1, 1'b1);

    // Overrun, then completion coinciding with acceptance
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("ovr_v1", v0, 1'b1);
    chk8("ovr_d1", data0, 8'h11);
    cyc(0, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("ovr_pulse", ov0, 1'b1);
    chk8("ovr_keep", data0, 8'h11);
    chk1("ovr_keep_v", v0, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b0);
    chk1("ovr_once", ov0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
    chk8("acc_load", data0, 8'h22);
    chk1("acc_valid", v0, 1'b1);
    chk1("acc_no_ovr", ov0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b1);
    chk1("acc_drop", v0, 1'b0);

    // Reset mid-frame while a frame is held
    send_frame(0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("mid_pre_v", v0, 1'b1);
    cyc(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk1("mid_rst_v", v0, 1'b0);
    chk8("mid_rst_d", data0, 8'h00);
    chk1("mid_rst_pe", pe0, 1'b0);
    chk1("mid_rst_fe", fe0, 1'b0);
    chk1("mid_rst_ov", ov0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
    chk1("mid_after_v", v0, 1'b1);
    chk8("mid_after_d", data0, 8'hA5);
    cyc(0, 1'b0, 1'b1, 1'b1);

    // Randomized tick gaps against the frame model
    random_run(0);
    random_run(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_deframer.md
RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter PARITY_EN, default 0; 1 = one even-parity bit follows the data bits.
REQ-003 The block SHALL have port sc_clk_ctrl  input  1  single clock; all state updates on its falling edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port S_data_in  input  1  sampled serial bit from the sampling stage.
REQ-006 The block SHALL have port bit_tick  input  1  one-cycle strobe; S_data_in is a valid bit sample in that cycle.
REQ-007 The block SHALL have port rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-008 The block SHALL have port rx_data  output  8  received byte, LSB = first data bit, unused MSBs 0.
REQ-009 The block SHALL have port rx_valid  output  1  rx_data/rx_parity_err hold a frame not yet accepted.
REQ-010 The block SHALL have port rx_parity_err  output  1  parity mismatch for the frame in rx_data (0 when PARITY_EN=0).
REQ-011 The block SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-012 The block SHALL have port overrun  output  1  one-cycle pulse: completed frame dropped because the buffer was full.

Function
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY, STOP, WAIT_IDLE; state changes occur only in bit_tick cycles.
REQ-014 In IDLE, bit_tick with S_data_in=0 SHALL go to DATA with bit counter 0 and shift register 0; S_data_in=1 stays IDLE.
REQ-015 In DATA, each bit_tick SHALL shift S_data_in in LSB-first and increment the counter; after bit DATA_BITS-1 go to PARITY if PARITY_EN else STOP.
REQ-016 In PARITY, bit_tick SHALL capture err = XOR(data bits, S_data_in) (even parity), then go to STOP.
REQ-017 In STOP, bit_tick with S_data_in=1 SHALL complete the frame and go to IDLE.
REQ-018 In STOP, bit_tick with S_data_in=0 SHALL pulse frame_err the next cycle, discard the frame, and go to WAIT_IDLE.
REQ-019 In WAIT_IDLE, bit_tick with S_data_in=1 SHALL go to IDLE; S_data_in=0 stays (line break held).
REQ-020 A completed frame SHALL load rx_data/rx_parity_err and set rx_valid on the falling edge ending the stop-bit tick cycle (latency 1 cycle).
REQ-021 rx_valid SHALL stay high and rx_data stable until a cycle with rx_valid & rx_ready; rx_valid then clears unless a frame completes in the same cycle.
REQ-022 Completion while rx_valid=1 without acceptance in the same cycle SHALL keep the old data and pulse overrun for one cycle.
REQ-023 Completion in the same cycle as acceptance SHALL load the new frame, keep rx_valid=1, and SHALL NOT pulse overrun.
REQ-024 Cycles without bit_tick SHALL NOT change FSM, counter or shift register; S_data_in is ignored.
REQ-025 Parity error frames SHALL still be delivered, with rx_parity_err=1.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, counter 0, shift register 0, rx_data 8'h00, rx_valid 0, rx_parity_err 0, frame_err 0, overrun 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; reception restarts at the next start bit after release.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, DATA_BITS default and bit-counter width constant.
REQ-029 The single-entry holding register and valid/overrun logic SHALL be a sub-module named rx_out_buffer.

Verification
REQ-030 8N1, bits 0,1,0,1,0,1,0,0 (0x2A) after start, stop=1, rx_ready=1 -> rx_data=8'h2A, rx_valid one cycle, no error pulses.
REQ-031 PARITY_EN=1, 0x0F, parity bit 1 -> rx_data=8'h0F, rx_parity_err=1; parity bit 0 -> rx_parity_err=0.
REQ-032 Stop bit 0 -> frame_err pulses once, rx_valid stays 0; line held 0 for 3 ticks, then 1, then frame 0x55 -> 0x55 received.
REQ-033 rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 8'h11, overrun pulses once; rx_ready=1 at 0x22 completion -> rx_data=8'h22, no overrun.
REQ-034 Reset asserted after the 4th data bit -> all outputs 0 at once; next full frame 0xA5 -> rx_data=8'hA5.
REQ-035 bit_tick gaps of 0..15 cycles with random S_data_in between ticks -> received bytes identical to gapless run.
